// File: rtl/fpu_seq_pkg.sv
// ---------------------------------------------------------------------------
// fpu_seq_pkg
// Shared types and helpers for the wide-to-narrow FPU beat sequencer.
//   - ST_* / state_e : sequencer FSM encoding
//   - fpu_beat_req_t : registered per-operation control fields
//   - calc_beats()   : number of narrow beats per wide request
//   - calc_bw()      : width of a beat index (at least 1 bit)
// ---------------------------------------------------------------------------
package fpu_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN,
        RESP  = ST_RESP
    } state_e;

    typedef struct packed {
        logic [2:0] rm;
        logic [4:0] op;
        logic [2:0] src_fmt;
        logic [2:0] dst_fmt;
        logic [1:0] int_fmt;
    } fpu_beat_req_t;

    function automatic int calc_beats(input int lanes, input int fpu_lanes);
        return lanes / fpu_lanes;
    endfunction

    function automatic int calc_bw(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/fpu_seq_collect.sv
// ---------------------------------------------------------------------------
// fpu_seq_collect
// Result reassembly buffer and status accumulator for the beat sequencer.
// Each returning beat is written into the slot named by its index; status
// flags are OR-ed across beats. Both are zeroed at the start of an
// operation and on flush.
// Ports:
//   clock, reset      clock / asynchronous active-low reset
//   clear             zero the buffer and status (start or flush)
//   wr_en             a beat result is returning this cycle
//   wr_idx            beat index (slot) of the returning result
//   wr_data           narrow beat result
//   wr_status         beat status flags
//   result            reassembled wide result (slot b at [b*FWIDTH +: FWIDTH])
//   status            OR of all returned beat status flags
// ---------------------------------------------------------------------------
module fpu_seq_collect #(
    parameter int BEATS  = 4,
    parameter int FWIDTH = 128,
    parameter int BW     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [BW-1:0]           wr_idx,
    input  logic [FWIDTH-1:0]       wr_data,
    input  logic [4:0]              wr_status,
    output logic [BEATS*FWIDTH-1:0] result,
    output logic [4:0]              status
);

    logic [BEATS-1:0][FWIDTH-1:0] slot_q;
    logic [4:0]                   status_q;

    // NOTE: the slot buffer is reset rather than left uninitialised because
    // the response result has a defined value (zero) straight out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q   <= '0;
            status_q <= '0;
        end else if (clear) begin
            slot_q   <= '0;
            status_q <= '0;
        end else if (wr_en) begin
            slot_q[wr_idx] <= wr_data;
            status_q       <= status_q | wr_status;
        end
    end

    assign result = slot_q;
    assign status = status_q;

endmodule

// File: rtl/fpu_beat_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_beat_sequencer
// Front-end that serialises one wide SIMD fp32 request (LANES lanes) into
// BEATS = LANES/FPU_LANES beats on a narrow FPU, collects the in-order beat
// results, and returns one wide response with OR-ed status and the caller tag.
//
// Optional feature (macro FPU_BEAT_SKIP_EN): beats whose mask slice is all
// zero are not issued; their result slot stays zero. An all-zero mask goes
// straight from IDLE to RESP.
//
// Ports:
//   clock, reset                      clock / asynchronous active-low reset
//   req_valid/req_ready               wide request handshake
//   req_bits_operands_0/1/2           wide operands (WIDTH)
//   req_bits_roundingMode/op/...      control fields, captured on accept
//   req_bits_tag, req_bits_simdMask   caller tag, per-lane enable
//   flush                             abort current operation (any state)
//   resp_valid/resp_ready             wide response handshake
//   resp_bits_result/status/tag       reassembled result, OR-ed flags, tag
//   busy                              high whenever not IDLE
//   fpu_req_*                         narrow beat issue (tag = beat index)
//   fpu_flush                         flush passed straight to the FPU
//   fpu_resp_*                        narrow beat result return
// ---------------------------------------------------------------------------
module fpu_beat_sequencer
    import fpu_seq_pkg::*;
#(
    parameter  int LANES     = 16,
    parameter  int FPU_LANES = 4,
    parameter  int TAG_WIDTH = 1,
    localparam int WIDTH     = 32 * LANES,
    localparam int FWIDTH    = 32 * FPU_LANES,
    localparam int BEATS     = calc_beats(LANES, FPU_LANES),
    localparam int BW        = calc_bw(BEATS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_bits_operands_0,
    input  logic [WIDTH-1:0]     req_bits_operands_1,
    input  logic [WIDTH-1:0]     req_bits_operands_2,
    input  logic [2:0]           req_bits_roundingMode,
    input  logic [4:0]           req_bits_op,
    input  logic [2:0]           req_bits_srcFormat,
    input  logic [2:0]           req_bits_dstFormat,
    input  logic [1:0]           req_bits_intFormat,
    input  logic [TAG_WIDTH-1:0] req_bits_tag,
    input  logic [LANES-1:0]     req_bits_simdMask,
    input  logic                 flush,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WIDTH-1:0]     resp_bits_result,
    output logic [4:0]           resp_bits_status,
    output logic [TAG_WIDTH-1:0] resp_bits_tag,
    output logic                 busy,
    output logic                 fpu_req_valid,
    input  logic                 fpu_req_ready,
    output logic [FWIDTH-1:0]    fpu_req_operands_0,
    output logic [FWIDTH-1:0]    fpu_req_operands_1,
    output logic [FWIDTH-1:0]    fpu_req_operands_2,
    output logic [2:0]           fpu_req_roundingMode,
    output logic [4:0]           fpu_req_op,
    output logic [2:0]           fpu_req_srcFormat,
    output logic [2:0]           fpu_req_dstFormat,
    output logic [1:0]           fpu_req_intFormat,
    output logic [BW-1:0]        fpu_req_tag,
    output logic [FPU_LANES-1:0] fpu_req_simdMask,
    output logic                 fpu_flush,
    input  logic                 fpu_resp_valid,
    output logic                 fpu_resp_ready,
    input  logic [FWIDTH-1:0]    fpu_resp_result,
    input  logic [4:0]           fpu_resp_status,
    input  logic [BW-1:0]        fpu_resp_tag
);

    state_e                          state_q;
    logic [BEATS-1:0][FWIDTH-1:0]    op0_q, op1_q, op2_q;
    logic [BEATS-1:0][FPU_LANES-1:0] mask_q;
    fpu_beat_req_t                   ctl_q;
    logic [TAG_WIDTH-1:0]            tag_q;
    logic [BW-1:0]                   ptr_q;
    logic [BW:0]                     issue_cnt_q, ret_cnt_q;
    logic [BW:0]                     issue_cnt_n, ret_cnt_n;

    logic          accept, fire_req, fire_ret;
    logic          has_next, start_empty;
    logic [BW-1:0] next_ptr, first_ptr;

    // Handshakes. Flush masks req_ready so a same-cycle request is refused.
    assign req_ready      = (state_q == IDLE) && !flush;
    assign accept         = req_valid && req_ready;
    assign fpu_req_valid  = (state_q == ISSUE);
    assign fpu_resp_ready = (state_q == ISSUE) || (state_q == DRAIN);
    assign fire_req       = fpu_req_valid && fpu_req_ready;
    assign fire_ret       = fpu_resp_valid && fpu_resp_ready;
    assign resp_valid     = (state_q == RESP);
    assign busy           = (state_q != IDLE);
    assign fpu_flush      = flush;

    // Beat datapath: slice of the captured request selected by the pointer.
    assign fpu_req_operands_0   = op0_q[ptr_q];
    assign fpu_req_operands_1   = op1_q[ptr_q];
    assign fpu_req_operands_2   = op2_q[ptr_q];
    assign fpu_req_simdMask     = mask_q[ptr_q];
    assign fpu_req_tag          = ptr_q;
    assign fpu_req_roundingMode = ctl_q.rm;
    assign fpu_req_op           = ctl_q.op;
    assign fpu_req_srcFormat    = ctl_q.src_fmt;
    assign fpu_req_dstFormat    = ctl_q.dst_fmt;
    assign fpu_req_intFormat    = ctl_q.int_fmt;
    assign resp_bits_tag        = tag_q;

    assign issue_cnt_n = issue_cnt_q + {{BW{1'b0}}, fire_req};
    assign ret_cnt_n   = ret_cnt_q + {{BW{1'b0}}, fire_ret};

`ifdef FPU_BEAT_SKIP_EN
    logic [BEATS-1:0][FPU_LANES-1:0] req_mask_v;
    assign req_mask_v = req_bits_simdMask;

    // Find the lowest non-empty beat above the pointer (and, for a new
    // request, the lowest non-empty beat overall) in a single cycle.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        has_next    = 1'b0;
        next_ptr    = ptr_q;
        start_empty = 1'b1;
        first_ptr   = '0;
        for (int b = BEATS - 1; b >= 0; b--) begin
            if ((b > int'(ptr_q)) && (|mask_q[b])) begin
                has_next = 1'b1;
                next_ptr = BW'(b);
            end
            if (|req_mask_v[b]) begin
                start_empty = 1'b0;
                first_ptr   = BW'(b);
            end
        end
    end
`else
    // Every beat is issued in order regardless of the mask.
    always_comb begin
        has_next    = (ptr_q != BW'(BEATS - 1));
        next_ptr    = ptr_q + 1'b1;
        start_empty = 1'b0;
        first_ptr   = '0;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            op0_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            mask_q      <= '0;
            ctl_q       <= '0;
            tag_q       <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op0_q       <= req_bits_operands_0;
                        op1_q       <= req_bits_operands_1;
                        op2_q       <= req_bits_operands_2;
                        mask_q      <= req_bits_simdMask;
                        ctl_q       <= '{rm:      req_bits_roundingMode,
                                         op:      req_bits_op,
                                         src_fmt: req_bits_srcFormat,
                                         dst_fmt: req_bits_dstFormat,
                                         int_fmt: req_bits_intFormat};
                        tag_q       <= req_bits_tag;
                        ptr_q       <= first_ptr;
                        issue_cnt_q <= '0;
                        ret_cnt_q   <= '0;
                        state_q     <= start_empty ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    issue_cnt_q <= issue_cnt_n;
                    ret_cnt_q   <= ret_cnt_n;
                    if (fire_req) begin
                        if (has_next) begin
                            ptr_q <= next_ptr;
                        end else begin
                            // A return landing with the final issue may
                            // already complete the set.
                            state_q <= (ret_cnt_n == issue_cnt_n) ? RESP : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    ret_cnt_q <= ret_cnt_n;
                    if (ret_cnt_n == issue_cnt_q) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fpu_seq_collect #(
        .BEATS (BEATS),
        .FWIDTH(FWIDTH),
        .BW    (BW)
    ) u_collect (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept || flush),
        .wr_en    (fire_ret),
        .wr_idx   (fpu_resp_tag),
        .wr_data  (fpu_resp_result),
        .wr_status(fpu_resp_status),
        .result   (resp_bits_result),
        .status   (resp_bits_status)
    );

endmodule

// File: tb/tb_fpu_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_beat_sequencer
// Directed bench for fpu_beat_sequencer (LANES=16, FPU_LANES=4, TAG_WIDTH=1)
// with a two-stage (L=2) fixed-latency FPU model. Expected results are
// lane-wise op0+op1+op2 of the bench's own operand vectors. Builds with or
// without FPU_BEAT_SKIP_EN; expectations adapt to the build.
// ---------------------------------------------------------------------------
module tb_fpu_beat_sequencer;

    localparam int LANES     = 16;
    localparam int FPU_LANES = 4;
    localparam int TAG_WIDTH = 1;
    localparam int WIDTH     = 32 * LANES;
    localparam int FWIDTH    = 32 * FPU_LANES;
    localparam int BEATS     = LANES / FPU_LANES;
    localparam int BW        = 2;
`ifdef FPU_BEAT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                 clock;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     req_bits_operands_0, req_bits_operands_1, req_bits_operands_2;
    logic [2:0]           req_bits_roundingMode;
    logic [4:0]           req_bits_op;
    logic [2:0]           req_bits_srcFormat, req_bits_dstFormat;
    logic [1:0]           req_bits_intFormat;
    logic [TAG_WIDTH-1:0] req_bits_tag;
    logic [LANES-1:0]     req_bits_simdMask;
    logic                 flush;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [WIDTH-1:0]     resp_bits_result;
    logic [4:0]           resp_bits_status;
    logic [TAG_WIDTH-1:0] resp_bits_tag;
    logic                 busy;
    logic                 fpu_req_valid;
    logic                 fpu_req_ready = 1'b1;
    logic [FWIDTH-1:0]    fpu_req_operands_0, fpu_req_operands_1, fpu_req_operands_2;
    logic [2:0]           fpu_req_roundingMode;
    logic [4:0]           fpu_req_op;
    logic [2:0]           fpu_req_srcFormat, fpu_req_dstFormat;
    logic [1:0]           fpu_req_intFormat;
    logic [BW-1:0]        fpu_req_tag;
    logic [FPU_LANES-1:0] fpu_req_simdMask;
    logic                 fpu_flush;
    logic                 fpu_resp_valid;
    logic                 fpu_resp_ready;
    logic [FWIDTH-1:0]    fpu_resp_result;
    logic [4:0]           fpu_resp_status;
    logic [BW-1:0]        fpu_resp_tag;

    int total = 0;
    int bad   = 0;

    fpu_beat_sequencer #(
        .LANES(LANES), .FPU_LANES(FPU_LANES), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bits_operands_0(req_bits_operands_0),
        .req_bits_operands_1(req_bits_operands_1),
        .req_bits_operands_2(req_bits_operands_2),
        .req_bits_roundingMode(req_bits_roundingMode),
        .req_bits_op(req_bits_op),
        .req_bits_srcFormat(req_bits_srcFormat),
        .req_bits_dstFormat(req_bits_dstFormat),
        .req_bits_intFormat(req_bits_intFormat),
        .req_bits_tag(req_bits_tag),
        .req_bits_simdMask(req_bits_simdMask),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bits_result(resp_bits_result),
        .resp_bits_status(resp_bits_status),
        .resp_bits_tag(resp_bits_tag),
        .busy(busy),
        .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready),
        .fpu_req_operands_0(fpu_req_operands_0),
        .fpu_req_operands_1(fpu_req_operands_1),
        .fpu_req_operands_2(fpu_req_operands_2),
        .fpu_req_roundingMode(fpu_req_roundingMode),
        .fpu_req_op(fpu_req_op),
        .fpu_req_srcFormat(fpu_req_srcFormat),
        .fpu_req_dstFormat(fpu_req_dstFormat),
        .fpu_req_intFormat(fpu_req_intFormat),
        .fpu_req_tag(fpu_req_tag),
        .fpu_req_simdMask(fpu_req_simdMask),
        .fpu_flush(fpu_flush),
        .fpu_resp_valid(fpu_resp_valid), .fpu_resp_ready(fpu_resp_ready),
        .fpu_resp_result(fpu_resp_result),
        .fpu_resp_status(fpu_resp_status),
        .fpu_resp_tag(fpu_resp_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bench-owned operand vectors of the current operation.
    logic [WIDTH-1:0] cur_a0, cur_a1, cur_a2;

    // ---------------- FPU model: lane-wise a+b+c, latency 2 ----------------
    int            stat_beat = -1;
    logic [4:0]    stat_val  = 5'b0;
    logic          s1_v, s2_v;
    logic [FWIDTH-1:0] s1_r, s2_r;
    logic [4:0]    s1_s, s2_s;
    logic [BW-1:0] s1_t, s2_t;
    int            n_fired, n_ret;
    logic [BW-1:0]        fired_tag [8];
    logic [FPU_LANES-1:0] fired_mask[8];
    logic [BW-1:0]        ret_tag   [8];

    function automatic logic [FWIDTH-1:0] lane_sum(input logic [FWIDTH-1:0] a,
                                                   input logic [FWIDTH-1:0] b,
                                                   input logic [FWIDTH-1:0] c);
        logic [FWIDTH-1:0] r;
        for (int i = 0; i < FPU_LANES; i++)
            r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32] + c[i*32 +: 32];
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_v <= 1'b0; s2_v <= 1'b0; n_fired <= 0; n_ret <= 0;
        end else begin
            if (flush) begin
                s1_v <= 1'b0; s2_v <= 1'b0;
            end else begin
                s1_v <= fpu_req_valid && fpu_req_ready;
                s1_r <= lane_sum(fpu_req_operands_0, fpu_req_operands_1, fpu_req_operands_2);
                s1_t <= fpu_req_tag;
                s1_s <= (int'(fpu_req_tag) == stat_beat) ? stat_val : 5'b0;
                s2_v <= s1_v; s2_r <= s1_r; s2_t <= s1_t; s2_s <= s1_s;
            end
            if (!busy) begin
                n_fired <= 0; n_ret <= 0;
            end else begin
                if (fpu_req_valid && fpu_req_ready) begin
                    if (n_fired < 8) begin
                        fired_tag[n_fired]  <= fpu_req_tag;
                        fired_mask[n_fired] <= fpu_req_simdMask;
                    end
                    n_fired <= n_fired + 1;
                end
                if (fpu_resp_valid && fpu_resp_ready) begin
                    if (n_ret < 8) ret_tag[n_ret] <= fpu_resp_tag;
                    n_ret <= n_ret + 1;
                end
            end
        end
    end

    assign fpu_resp_valid  = s2_v;
    assign fpu_resp_result = s2_r;
    assign fpu_resp_status = s2_s;
    assign fpu_resp_tag    = s2_t;

    // ---------------- FPU ready driver with optional stall ----------------
    int stall_beat = -1;
    int stall_len  = 0;
    int stall_seen = 0;

    always @(negedge clock) begin
        if (!busy) stall_seen = 0;
        if (fpu_req_valid && int'(fpu_req_tag) == stall_beat && stall_seen < stall_len) begin
            if (stall_seen > 0) begin
                check("stall_hold_tag", fpu_req_tag, stall_beat);
                check("stall_hold_op", fpu_req_operands_0, cur_a0[stall_beat*FWIDTH +: FWIDTH]);
            end
            fpu_req_ready = 1'b0;
            stall_seen++;
        end else begin
            fpu_req_ready = 1'b1;
        end
    end

    // ---------------- operation task ----------------
    task automatic build_ops(input int pat);
        for (int i = 0; i < LANES; i++) begin
            cur_a0[i*32 +: 32] = i;
            cur_a1[i*32 +: 32] = (pat != 0) ? 32'h1000_0000 + i * 16 : 32'h0;
            cur_a2[i*32 +: 32] = (pat != 0) ? i * 256 : 32'h0;
        end
    endtask

    task automatic run_op(input logic [LANES-1:0] mask, input logic [TAG_WIDTH-1:0] tag,
                          input int pat, input int sbeat, input logic [4:0] sval,
                          input int stall, input int hold);
        logic [WIDTH-1:0] exp_res;
        logic [4:0]       exp_st;
        int               exp_beats[BEATS];
        int               exp_n, exp_cyc, k;
        bit               stall_hit;
        build_ops(pat);
        exp_res = '0; exp_st = '0; exp_n = 0; stall_hit = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (!SKIP || (|mask[b*FPU_LANES +: FPU_LANES])) begin
                exp_beats[exp_n] = b;
                exp_n++;
                if (b == sbeat) exp_st = exp_st | sval;
                if (b == 1 && stall > 0) stall_hit = 1'b1;
                for (int i = b * FPU_LANES; i < (b + 1) * FPU_LANES; i++)
                    exp_res[i*32 +: 32] = cur_a0[i*32 +: 32] + cur_a1[i*32 +: 32] + cur_a2[i*32 +: 32];
            end
        end
        exp_cyc    = (exp_n == 0) ? 1 : exp_n + 3 + (stall_hit ? stall : 0);
        stat_beat  = sbeat;
        stat_val   = sval;
        stall_beat = (stall > 0) ? 1 : -1;
        stall_len  = stall;

        @(negedge clock);
        req_bits_operands_0   = cur_a0;
        req_bits_operands_1   = cur_a1;
        req_bits_operands_2   = cur_a2;
        req_bits_roundingMode = 3'b001;
        req_bits_op           = 5'b00010;
        req_bits_srcFormat    = 3'b000;
        req_bits_dstFormat    = 3'b001;
        req_bits_intFormat    = 2'b10;
        req_bits_tag          = tag;
        req_bits_simdMask     = mask;
        req_valid             = 1'b1;
        resp_ready            = (hold == 0);
        check("accept_ready", req_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        if (exp_n > 0) begin
            check("first_beat", {fpu_req_valid, fpu_req_tag}, {1'b1, BW'(exp_beats[0])});
            check("fpu_ctl", {fpu_req_roundingMode, fpu_req_op, fpu_req_srcFormat,
                              fpu_req_dstFormat, fpu_req_intFormat},
                  {3'b001, 5'b00010, 3'b000, 3'b001, 2'b10});
        end
        k = 1;
        while (!resp_valid && k < 60) begin
            @(negedge clock);
            k++;
        end
        check("resp_cycle", k, exp_cyc);
        check("resp_result", resp_bits_result, exp_res);
        check("resp_status", resp_bits_status, exp_st);
        check("resp_tag", resp_bits_tag, tag);
        check("resp_req_ready", req_ready, 1'b0);
        check("beats_issued", n_fired, exp_n);
        check("beats_returned", n_ret, exp_n);
        for (int j = 0; j < exp_n; j++) begin
            check("issue_tag", fired_tag[j], exp_beats[j]);
            check("issue_mask", fired_mask[j], mask[exp_beats[j]*FPU_LANES +: FPU_LANES]);
            check("return_tag", ret_tag[j], exp_beats[j]);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clock);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_result", resp_bits_result, exp_res);
            check("hold_req_ready", req_ready, 1'b0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        check("idle_after", {busy, resp_valid}, 2'b00);
    endtask

    task automatic run_flush();
        int k;
        build_ops(0);
        stat_beat = -1; stall_beat = -1; stall_len = 0;
        @(negedge clock);
        req_bits_operands_0 = cur_a0;
        req_bits_operands_1 = cur_a1;
        req_bits_operands_2 = cur_a2;
        req_bits_simdMask   = '1;
        req_bits_tag        = 1'b1;
        req_valid           = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        k = 0;
        while (n_ret < 2 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("flush_wait", n_ret, 2);
        check("flush_in_drain", {busy, fpu_req_valid}, 2'b10);
        flush     = 1'b1;
        req_valid = 1'b1;
        #1;
        check("fpu_flush", fpu_flush, 1'b1);
        check("flush_req_ready", req_ready, 1'b0);
        @(negedge clock);
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_resp_valid", resp_valid, 1'b0);
        check("flush_result_clr", resp_bits_result, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        req_bits_operands_0 = '0; req_bits_operands_1 = '0; req_bits_operands_2 = '0;
        req_bits_roundingMode = '0; req_bits_op = '0; req_bits_srcFormat = '0;
        req_bits_dstFormat = '0; req_bits_intFormat = '0; req_bits_tag = '0;
        req_bits_simdMask = '0;
        cur_a0 = '0; cur_a1 = '0; cur_a2 = '0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fpu_req_valid", fpu_req_valid, 1'b0);
        check("rst_fpu_resp_ready", fpu_resp_ready, 1'b0);
        check("rst_result", resp_bits_result, '0);
        check("rst_status", resp_bits_status, 5'b0);
        check("rst_tag", resp_bits_tag, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        run_op(16'hFFFF, 1'b1, 0, -1, 5'b00000, 0, 0);   // basic: lane i = i
        run_op(16'hFFFF, 1'b0, 1,  2, 5'b00001, 0, 0);   // status on beat 2
        run_op(16'hFFFF, 1'b1, 1,  0, 5'b10000, 3, 0);   // beat 1 stalled 3 cycles
        run_op(16'h0F0F, 1'b0, 0, -1, 5'b00000, 0, 5);   // resp_ready low 5 cycles
        run_flush();                                     // flush in DRAIN
        run_op(16'hFFFF, 1'b1, 1,  3, 5'b00100, 0, 0);   // clean op after flush
        run_op(16'h0000, 1'b1, 1,  1, 5'b01000, 0, 0);   // all-zero mask

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_beat_sequencer.md
Name: fpu_beat_sequencer

Overview:
- Front-end for a narrow fpnew-based vector FPU: accepts one wide SIMD fp32 request (LANES lanes) and issues it as BEATS = LANES/FPU_LANES sequential beats to an FPU_LANES-wide FPU.
- Collects in-order beat results, reassembles the wide result, ORs the status flags and returns one response carrying the original tag.
- Sits between the core's wide FPU request port and a narrower CVFPU-style instance, trading throughput for area.

Parameters:
- LANES, 16, lanes in the wide request (fp32 each).
- FPU_LANES, 4, lanes per FPU beat; must divide LANES and be at least 1.
- TAG_WIDTH, 1, width of the caller tag.
- Derived, not overridable: WIDTH = 32*LANES; FWIDTH = 32*FPU_LANES; BEATS = LANES/FPU_LANES; BW = max(1, clog2(BEATS)).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid/req_ready  in/out  1/1  wide request handshake.
- req_bits_operands_0/1/2  in  WIDTH  wide operands.
- req_bits_roundingMode  in  3  rounding mode.
- req_bits_op  in  5  {op[3:0], op_mod}.
- req_bits_srcFormat, req_bits_dstFormat  in  3 each  fp formats.
- req_bits_intFormat  in  2  int format.
- req_bits_tag  in  TAG_WIDTH  caller tag.
- req_bits_simdMask  in  LANES  per-lane enable.
- flush  in  1  abort the current operation.
- resp_valid/resp_ready  out/in  1/1  wide response handshake.
- resp_bits_result  out  WIDTH  reassembled result.
- resp_bits_status  out  5  OR of beat status flags.
- resp_bits_tag  out  TAG_WIDTH  captured request tag.
- busy  out  1  high whenever state is not IDLE.
- fpu_req_valid/fpu_req_ready  out/in  1/1  beat issue handshake.
- fpu_req_operands_0/1/2  out  FWIDTH  beat operand slices.
- fpu_req_roundingMode, fpu_req_op, fpu_req_srcFormat, fpu_req_dstFormat, fpu_req_intFormat  out  3/5/3/3/2  registered copies of the request fields.
- fpu_req_tag  out  BW  beat index.
- fpu_req_simdMask  out  FPU_LANES  beat mask slice.
- fpu_flush  out  1  equals flush (combinational).
- fpu_resp_valid/fpu_resp_ready  in/out  1/1  beat result handshake.
- fpu_resp_result  in  FWIDTH  beat result.
- fpu_resp_status  in  5  beat status.
- fpu_resp_tag  in  BW  beat index.

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready = 1; resp_valid = 0; busy = 0; fpu_req_valid = 0; fpu_resp_ready = 0.
  - resp_bits_result = 0; resp_bits_status = 0; resp_bits_tag = 0.
  - issue_cnt = 0; ret_cnt = 0.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture the operands, fields, tag and mask; clear the result buffer and status; go to ISSUE.
- ISSUE:
  - fpu_req_valid = 1.
  - Beat b carries slice [b*FWIDTH +: FWIDTH] of each operand, the mask slice [b*FPU_LANES +: FPU_LANES], and tag = b.
  - issue_cnt increments on fpu_req fire.
  - When the last beat fires, go to DRAIN.
- ISSUE and DRAIN:
  - fpu_resp_ready = 1.
  - On fpu_resp fire, write the result into slot fpu_resp_tag, OR fpu_resp_status into the status, and increment ret_cnt.
  - Issue and return may fire in the same cycle; both take effect.
  - When ret_cnt reaches the number of issued beats and issuing is done, go to RESP the next cycle. This also applies to a return in the ISSUE cycle that fires the final beat.
- RESP:
  - resp_valid = 1; outputs are stable until resp_ready.
  - On fire, go to IDLE.
  - req_ready is 0 in RESP, so there is no overlap.
- Latency: request accepted at cycle 0 → beat 0 valid at cycle 1. With ready FPU of latency L, resp_valid at cycle BEATS+L+1.
- fpu_resp_tag mismatching ret_cnt is an illegal stimulus. The bench asserts on it; the RTL trusts the tag.
- Flush, any state:
  - Next state is IDLE; counters cleared; resp_valid drops.
  - A same-cycle req is not accepted (req_ready forced 0 while flush).
- Reset mid-operation: asynchronous return to the reset values above, in-flight beats lost; the integrator also resets the FPU.

Optional Feature:
- Macro FPU_BEAT_SKIP_EN.
- Defined:
  - Beats whose mask slice is all zero are not issued; their result slot stays 0.
  - The issue pointer advances to the next non-empty beat in one cycle.
  - A fully zero mask goes IDLE→RESP directly, status 0.
- Undefined: all BEATS beats are always issued, whatever the mask.

Decomposition:
- Package fpu_seq_pkg:
  - state_e enum.
  - A function computing BEATS/BW.
  - A struct fpu_beat_req_t bundling the registered control fields (rm, op, fmts).
- Sub-module fpu_seq_collect: result buffer plus status accumulator, written by tag, cleared on start or flush.

Test Plan:
- LANES=16, FPU_LANES=4, FPU ready with L=2, operands of lane i = i → 4 beats, tags 0..3 in order, resp at cycle 7, result lanes = per-lane FPU output, resp_bits_tag echoed.
- Beat 2 returns status 5'b00001, others 0 → resp_bits_status = 5'b00001.
- fpu_req_ready low for 3 cycles on beat 1 → beat 1 operands/tag held stable, no duplicate, resp still correct.
- resp_ready held low 5 cycles → resp_valid and result stable, req_ready = 0, no new accept.
- Flush in DRAIN after 2 of 4 returns → IDLE next cycle, busy = 0, fpu_flush = 1 that cycle; the next request completes cleanly.
- With FPU_BEAT_SKIP_EN, mask = 16'h0F0F → only beats 0 and 2 issued, slots 1 and 3 zero. With mask = 0 → resp_valid at cycle 1, result 0.
